// File: rtl/gl_commit_ctrl.sv
// Two-wide graduation-list commit controller: in-order retirement, exception flush and CSR serialisation.
// Optional macro COMMIT_PERF_COUNTER_EN enables the 64-bit retired-instruction counter on instret_o.
module gl_commit_ctrl #(
  parameter int GL_ENTRIES   = 32,
  parameter int PC_W         = 40,
  parameter int FLUSH_CYCLES = 3,
  parameter int IDX_W        = $clog2(GL_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           head_valid_i,
  input  logic [1:0]           head_done_i,
  input  logic [1:0]           head_exc_i,
  input  logic [1:0]           head_csr_i,
  input  logic [1:0][5:0]      head_cause_i,
  input  logic [1:0][PC_W-1:0] head_pc_i,
  input  logic [IDX_W-1:0]     head_idx_i,
  input  logic                 csr_ack_i,
  output logic [1:0]           read_head_o,
  output logic [1:0]           retire_cnt_o,
  output logic                 csr_req_o,
  output logic                 exc_valid_o,
  output logic [5:0]           exc_cause_o,
  output logic [PC_W-1:0]      exc_pc_o,
  output logic                 flush_o,
  output logic                 flush_commit_o,
  output logic [IDX_W-1:0]     flush_index_o,
  output logic [63:0]          instret_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CSR_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       slot0_ready;
  logic       slot1_ready;
  logic       slot0_exc;
  logic       slot0_csr;
  logic       unused_slot1;

  // Exceptions are only taken from slot 0, so slot 1 cause/pc are never consumed.
  assign unused_slot1 = ^{head_cause_i[1], head_pc_i[1]};

  // Per-slot retire qualification and the combinational pop request.
  always_comb begin
    slot0_ready = head_valid_i[0] & head_done_i[0] & ~head_exc_i[0] & ~head_csr_i[0];
    slot1_ready = slot0_ready & head_valid_i[1] & head_done_i[1] & ~head_exc_i[1] & ~head_csr_i[1];
    slot0_exc   = head_valid_i[0] & head_done_i[0] & head_exc_i[0];
    slot0_csr   = head_valid_i[0] & head_done_i[0] & head_csr_i[0] & ~head_exc_i[0];
    read_head_o = 2'b00;
    if (rst_i) begin
      read_head_o = 2'b00;
    end else begin
      case (state)
        RUN: begin
          if (slot0_exc) begin
            read_head_o = 2'b01;
          end else begin
            read_head_o = {slot1_ready, slot0_ready};
          end
        end
        CSR_WAIT: begin
          if (csr_ack_i) begin
            read_head_o = 2'b01;
          end else begin
            read_head_o = 2'b00;
          end
        end
        FLUSH:   read_head_o = 2'b00;
        default: read_head_o = 2'b00;
      endcase
    end
  end

  // Commit FSM with registered retire count, exception and flush outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= RUN;
      flush_cnt      <= 4'd0;
      retire_cnt_o   <= 2'd0;
      csr_req_o      <= 1'b0;
      exc_valid_o    <= 1'b0;
      exc_cause_o    <= 6'd0;
      exc_pc_o       <= '0;
      flush_o        <= 1'b0;
      flush_commit_o <= 1'b0;
      flush_index_o  <= '0;
    end else begin
      retire_cnt_o   <= 2'd0;
      exc_valid_o    <= 1'b0;
      flush_o        <= 1'b0;
      flush_commit_o <= 1'b0;
      case (state)
        RUN: begin
          if (slot0_exc) begin
            state          <= FLUSH;
            flush_cnt      <= FLUSH_LAST;
            exc_valid_o    <= 1'b1;
            exc_cause_o    <= head_cause_i[0];
            exc_pc_o       <= head_pc_i[0];
            flush_o        <= 1'b1;
            flush_commit_o <= 1'b1;
            flush_index_o  <= head_idx_i;
          end else if (slot0_csr) begin
            state     <= CSR_WAIT;
            csr_req_o <= 1'b1;
          end else begin
            retire_cnt_o <= {1'b0, slot0_ready} + {1'b0, slot1_ready};
          end
        end
        CSR_WAIT: begin
          if (csr_ack_i) begin
            state        <= RUN;
            csr_req_o    <= 1'b0;
            retire_cnt_o <= 2'd1;
          end else begin
            csr_req_o <= 1'b1;
          end
        end
        FLUSH: begin
          // Counter was loaded with FLUSH_CYCLES-1, so the state lasts FLUSH_CYCLES cycles.
          if (flush_cnt == 4'd0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= RUN;
          flush_cnt <= 4'd0;
          csr_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef COMMIT_PERF_COUNTER_EN
  logic [63:0] instret;

  // Retired-instruction counter, wraps at 2^64.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret <= 64'd0;
    end else begin
      instret <= instret + {62'd0, retire_cnt_o};
    end
  end

  assign instret_o = instret;
`else
  assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_gl_commit_ctrl.sv
// Directed self-checking bench for gl_commit_ctrl (default parameters).
module tb_gl_commit_ctrl;

  localparam int PC_W  = 40;
  localparam int IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [1:0]           head_valid_i, head_done_i, head_exc_i, head_csr_i;
  logic [1:0][5:0]      head_cause_i;
  logic [1:0][PC_W-1:0] head_pc_i;
  logic [IDX_W-1:0]     head_idx_i;
  logic                 csr_ack_i;
  logic [1:0]           read_head_o, retire_cnt_o;
  logic                 csr_req_o, exc_valid_o, flush_o, flush_commit_o;
  logic [5:0]           exc_cause_o;
  logic [PC_W-1:0]      exc_pc_o;
  logic [IDX_W-1:0]     flush_index_o;
  logic [63:0]          instret_o;

  int n_assert = 0;
  int n_fail   = 0;

  gl_commit_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .head_valid_i(head_valid_i), .head_done_i(head_done_i),
    .head_exc_i(head_exc_i), .head_csr_i(head_csr_i),
    .head_cause_i(head_cause_i), .head_pc_i(head_pc_i),
    .head_idx_i(head_idx_i), .csr_ack_i(csr_ack_i),
    .read_head_o(read_head_o), .retire_cnt_o(retire_cnt_o),
    .csr_req_o(csr_req_o), .exc_valid_o(exc_valid_o),
    .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o),
    .flush_o(flush_o), .flush_commit_o(flush_commit_o),
    .flush_index_o(flush_index_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    head_valid_i = 2'b00; head_done_i = 2'b00; head_exc_i = 2'b00; head_csr_i = 2'b00;
    csr_ack_i = 1'b0;
  endtask

  function automatic logic [63:0] exp_instret(input logic [63:0] n);
`ifdef COMMIT_PERF_COUNTER_EN
    return n;
`else
    return 64'd0 & n;
`endif
  endfunction

  initial begin
    idle();
    head_cause_i = '0; head_pc_i = '0; head_idx_i = 5'd0;
    rst_i = 1'b1;
    head_valid_i = 2'b11; head_done_i = 2'b11;
    #1;
    chk("pop_in_reset", {62'd0, read_head_o}, 64'd0);
    step(); step();
    chk("rst_retire", {62'd0, retire_cnt_o}, 64'd0);
    chk("rst_outs", {60'd0, csr_req_o, exc_valid_o, flush_o, flush_commit_o}, 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    rst_i = 1'b0;
    idle();

    // GL empty: slot0 invalid, nothing pops
    head_done_i = 2'b11; #1;
    chk("empty_pop", {62'd0, read_head_o}, 64'd0);
    step();
    chk("empty_retire", {62'd0, retire_cnt_o}, 64'd0);

    // Ack outside CSR_WAIT is ignored
    csr_ack_i = 1'b1; #1;
    chk("stray_ack_pop", {62'd0, read_head_o}, 64'd0);
    step();
    chk("stray_ack_req", {63'd0, csr_req_o}, 64'd0);
    csr_ack_i = 1'b0;

    // Dual retire
    head_idx_i = 5'd3; head_valid_i = 2'b11; head_done_i = 2'b11; #1;
    chk("dual_pop", {62'd0, read_head_o}, 64'd3);
    step(); idle();
    chk("dual_retire", {62'd0, retire_cnt_o}, 64'd2);
    step();
    chk("dual_instret", instret_o, exp_instret(64'd2));

    // Slot1 not done
    head_valid_i = 2'b11; head_done_i = 2'b01; #1;
    chk("single_pop", {62'd0, read_head_o}, 64'd1);
    step(); idle();
    chk("single_retire", {62'd0, retire_cnt_o}, 64'd1);
    step();
    chk("single_instret", instret_o, exp_instret(64'd3));

    // Exception in slot1 only: slot0 retires alone
    head_valid_i = 2'b11; head_done_i = 2'b11; head_exc_i = 2'b10; #1;
    chk("s1exc_pop", {62'd0, read_head_o}, 64'd1);
    step(); idle();
    chk("s1exc_retire", {62'd0, retire_cnt_o}, 64'd1);
    chk("s1exc_noexc", {63'd0, exc_valid_o}, 64'd0);

    // CSR in slot1 only: slot0 retires alone
    head_valid_i = 2'b11; head_done_i = 2'b11; head_csr_i = 2'b10; #1;
    chk("s1csr_pop", {62'd0, read_head_o}, 64'd1);
    step(); idle();
    chk("s1csr_retire", {62'd0, retire_cnt_o}, 64'd1);
    chk("s1csr_noreq", {63'd0, csr_req_o}, 64'd0);

    // Slot0 exception: cause 1, pc 0x10, index 7
    head_idx_i = 5'd7; head_cause_i[0] = 6'd1; head_pc_i[0] = 40'h10;
    head_valid_i = 2'b01; head_done_i = 2'b01; head_exc_i = 2'b01; #1;
    chk("exc_pop", {62'd0, read_head_o}, 64'd1);
    step();
    head_valid_i = 2'b11; head_done_i = 2'b11; head_exc_i = 2'b00; #1;
    chk("exc_valid", {63'd0, exc_valid_o}, 64'd1);
    chk("exc_cause", {58'd0, exc_cause_o}, 64'd1);
    chk("exc_pc", {24'd0, exc_pc_o}, 64'h10);
    chk("flush_first", {62'd0, flush_o, flush_commit_o}, 64'd3);
    chk("flush_index", {59'd0, flush_index_o}, 64'd7);
    chk("flush_pop1", {62'd0, read_head_o}, 64'd0);
    step();
    chk("flush_once", {62'd0, flush_o, flush_commit_o}, 64'd0);
    chk("exc_pulse", {63'd0, exc_valid_o}, 64'd0);
    chk("flush_pop2", {62'd0, read_head_o}, 64'd0);
    step();
    chk("flush_pop3", {62'd0, read_head_o}, 64'd0);
    step();
    chk("flush_done_pop", {62'd0, read_head_o}, 64'd3);
    idle(); #1;

    // CSR in slot0, ack during 4th cycle of request
    head_valid_i = 2'b01; head_done_i = 2'b01; head_csr_i = 2'b01; #1;
    chk("csr_nopop", {62'd0, read_head_o}, 64'd0);
    step();
    chk("csr_req1", {63'd0, csr_req_o}, 64'd1);
    step();
    chk("csr_req2", {63'd0, csr_req_o}, 64'd1);
    chk("csr_wait_pop", {62'd0, read_head_o}, 64'd0);
    step();
    chk("csr_req3", {63'd0, csr_req_o}, 64'd1);
    step();
    chk("csr_req4", {63'd0, csr_req_o}, 64'd1);
    csr_ack_i = 1'b1; #1;
    chk("csr_ack_pop", {62'd0, read_head_o}, 64'd1);
    step(); idle();
    chk("csr_req_drop", {63'd0, csr_req_o}, 64'd0);
    chk("csr_retire", {62'd0, retire_cnt_o}, 64'd1);
    head_valid_i = 2'b11; head_done_i = 2'b11; #1;
    chk("csr_back_run", {62'd0, read_head_o}, 64'd3);
    idle(); step();

    // Index wrap at 31
    head_idx_i = 5'd31; head_valid_i = 2'b11; head_done_i = 2'b11; #1;
    chk("wrap_pop", {62'd0, read_head_o}, 64'd3);
    step(); idle();
    chk("wrap_retire", {62'd0, retire_cnt_o}, 64'd2);
    chk("wrap_nox", {63'd0, $isunknown({read_head_o, retire_cnt_o, csr_req_o, exc_valid_o,
        exc_cause_o, exc_pc_o, flush_o, flush_commit_o, flush_index_o, instret_o})}, 64'd0);

    // Reset during FLUSH
    head_idx_i = 5'd5; head_valid_i = 2'b01; head_done_i = 2'b01; head_exc_i = 2'b01;
    step(); idle();
    chk("rflush_flush", {63'd0, flush_o}, 64'd1);
    chk("rflush_index", {59'd0, flush_index_o}, 64'd5);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    head_valid_i = 2'b11; head_done_i = 2'b11; #1;
    chk("rflush_flush_off", {62'd0, flush_o, exc_valid_o}, 64'd0);
    chk("rflush_run_pop", {62'd0, read_head_o}, 64'd3);
    chk("rflush_instret", instret_o, 64'd0);
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
